// File: rtl/fir_mac_secuencial.sv
// fir_mac_secuencial: time-multiplexed FIR tap engine.
// One accepted sample shifts the delay line, then one tap per clock is fed to
// the external saturating adder (Suma) and its result is registered back into
// the accumulator. The finished sample is presented with a one-cycle strobe.
module fir_mac_secuencial #(
  parameter int Width = 25,
  parameter int Frac  = 10,
  parameter int Taps  = 5,
  parameter int AddrW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] muestra_in,
  input  logic             muestra_valid,
  input  logic             coef_we,
  input  logic [AddrW-1:0] coef_addr,
  input  logic [Width-1:0] coef_in,
  output logic [Width-1:0] suma_a,
  output logic [Width-1:0] suma_b,
  input  logic [Width-1:0] suma_y,
  output logic [Width-1:0] salida,
  output logic             salida_valid,
  output logic             ocupado
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Symmetric clamp limits for the rescaled product, +/-(2^(Width-1)-1).
  localparam logic signed [2*Width-1:0] sat_max = {{(Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [2*Width-1:0] sat_min = -sat_max;

  state_t                  state;
  logic signed [Width-1:0] x_reg [Taps];
  logic signed [Width-1:0] h_reg [Taps];
  logic signed [Width-1:0] acc;
  logic [AddrW-1:0]        idx;

  logic signed [Width-1:0]   x_sel;
  logic signed [Width-1:0]   h_sel;
  logic signed [2*Width-1:0] prod;
  logic signed [2*Width-1:0] prod_shift;
  logic signed [Width-1:0]   prod_sat;
  logic                      accept;
  logic                      coef_ok;

  // A new sample is taken only while idle; busy-time strobes are dropped.
  assign accept  = (state == IDLE) && muestra_valid;
  assign coef_ok = (state == IDLE) && coef_we && (32'(coef_addr) < 32'(Taps));

  // Delay line and coefficient bank, one register pair per tap.
  generate
    for (genvar gi = 0; gi < Taps; gi++) begin : g_tap
      // Shift the delay line on each accepted sample.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg[gi] <= '0;
        end else if (accept) begin
          if (gi == 0) begin
            x_reg[gi] <= $signed(muestra_in);
          end else begin
            x_reg[gi] <= x_reg[(gi > 0) ? gi - 1 : 0];
          end
        end
      end

      // Coefficient write, only while idle so a running MAC sees stable taps.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          h_reg[gi] <= '0;
        end else if (coef_ok && (coef_addr == AddrW'(gi))) begin
          h_reg[gi] <= $signed(coef_in);
        end
      end
    end
  endgenerate

  // Select the tap addressed by idx (explicit mux keeps idx in range).
  always_comb begin
    x_sel = '0;
    h_sel = '0;
    for (int k = 0; k < Taps; k++) begin
      if (idx == AddrW'(k)) begin
        x_sel = x_reg[k];
        h_sel = h_reg[k];
      end
    end
  end

  // Full-width product, arithmetic rescale, then symmetric clamp.
  always_comb begin
    prod       = $signed({{Width{x_sel[Width-1]}}, x_sel}) *
                 $signed({{Width{h_sel[Width-1]}}, h_sel});
    prod_shift = prod >>> Frac;
    if (prod_shift > sat_max) begin
      prod_sat = sat_max[Width-1:0];
    end else if (prod_shift < sat_min) begin
      prod_sat = sat_min[Width-1:0];
    end else begin
      prod_sat = prod_shift[Width-1:0];
    end
  end

  assign suma_a  = (state == MAC) ? acc : '0;
  assign suma_b  = (state == MAC) ? prod_sat : '0;
  assign ocupado = (state != IDLE);

  // Sequencer: accept sample, walk the taps through Suma, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      salida       <= '0;
      salida_valid <= 1'b0;
    end else begin
      salida_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (muestra_valid) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= $signed(suma_y);
          idx <= idx + AddrW'(1);
          if (idx == AddrW'(Taps - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          salida       <= acc;
          salida_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_secuencial.sv
// Testbench for fir_mac_secuencial: behavioural Suma model plus a tap-level
// reference model of the filter output, directed scenarios and random traffic.
module tb_fir_mac_secuencial;

  localparam int  W     = 25;
  localparam int  NT    = 5;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  muestra_in;
  logic          muestra_valid;
  logic          coef_we;
  logic [2:0]    coef_addr;
  logic [W-1:0]  coef_in;
  logic [W-1:0]  suma_a;
  logic [W-1:0]  suma_b;
  logic [W-1:0]  suma_y;
  logic [W-1:0]  salida;
  logic          salida_valid;
  logic          ocupado;

  int total = 0;
  int bad   = 0;

  longint hist [NT];
  longint hcoef[NT];

  fir_mac_secuencial #(.Width(W), .Frac(10), .Taps(NT), .AddrW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .muestra_in(muestra_in), .muestra_valid(muestra_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_in(coef_in),
    .suma_a(suma_a), .suma_b(suma_b), .suma_y(suma_y),
    .salida(salida), .salida_valid(salida_valid), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  // Suma: symmetric saturating adder, combinational.
  longint sum_tmp;
  always_comb begin
    sum_tmp = clampv(sx(suma_a) + sx(suma_b));
    suma_y  = sum_tmp[W-1:0];
  end

  // Reference filter output from the current history and coefficients.
  function automatic longint model_out();
    longint a;
    a = 0;
    for (int k = 0; k < NT; k++) begin
      a = clampv(a + clampv((hist[k] * hcoef[k]) >>> 10));
    end
    return a;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      hist[k]  = 0;
      hcoef[k] = 0;
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end at #1 after a rising edge.
  task automatic reset_dut();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [W-1:0] v);
    coef_we = 1'b1; coef_addr = a; coef_in = v;
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (a < NT) hcoef[a] = sx(v);
    $display("coef h[%0d] <= %0d", a, sx(v));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (ocupado !== 1'b0 && w < 50) begin
      @(posedge clk);
      #1 w++;
    end
    if (w >= 50) check("idle_timeout", w, 0);
  endtask

  // Send one sample; optional stray strobe / coef write at MAC cycle pulse_at / we_at.
  task automatic send_sample(input logic [W-1:0] v, input int pulse_at, input int we_at,
                             output longint got, output longint b0);
    int lat;
    longint exp;
    longint held;
    wait_idle();
    muestra_in = v; muestra_valid = 1'b1;
    @(posedge clk);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = sx(v);
    exp = model_out();
    #1 muestra_valid = 1'b0;
    b0 = sx(suma_b);
    check("busy_after_accept", ocupado, 1);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c == pulse_at) begin
        muestra_valid = 1'b1; muestra_in = W'($urandom);
      end
      if (c == we_at) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_in = W'($urandom);
      end
      @(posedge clk);
      #1;
      muestra_valid = 1'b0;
      coef_we = 1'b0;
      if (salida_valid === 1'b1) lat = c;
    end
    got = sx(salida);
    check("latency", lat, 6);
    check("salida", got, exp);
    held = got;
    @(posedge clk);
    #1;
    check("valid_one_cycle", salida_valid, 0);
    check("salida_hold", sx(salida), held);
    $display("sample x=%0d salida=%0d expected=%0d latency=%0d", sx(v), got, exp, lat);
  endtask

  longint got, b0, tmp;
  longint imp_tab[NT] = '{1024, 2048, 3072, 4096, 5120};
  int     vcount;

  initial begin
    // 1. Reset while strobes are active.
    rst_n = 1'b0; muestra_valid = 1'b1; coef_we = 1'b1;
    coef_addr = 3'd0; coef_in = W'(1024); muestra_in = W'(1024);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_salida", salida, 0);
    check("rst_valid", salida_valid, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_suma_a", suma_a, 0);
    check("rst_suma_b", suma_b, 0);
    muestra_valid = 1'b0; coef_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_sample(W'(1024), 0, 0, got, b0);
    check("rst_no_coef_out", got, 0);

    // 2. Impulse response.
    reset_dut();
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'(imp_tab[k]));
    for (int i = 0; i < NT; i++) begin
      send_sample((i == 0) ? W'(1024) : W'(0), 0, 0, got, b0);
      check("impulse", got, imp_tab[i]);
    end

    // 3. Product saturation.
    reset_dut();
    write_coef(3'd0, W'(16777215));
    send_sample(W'(16777215), 0, 0, got, b0);
    check("prod_sat_b0", b0, 16777215);
    check("prod_sat_out", got, 16777215);

    // 4. Accumulator saturation through Suma.
    reset_dut();
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'(8192));
    for (int i = 0; i < NT; i++) begin
      send_sample(W'(-2097152), 0, 0, got, b0);
      if (i == 0) check("acc_sat_b0", b0, -16777215);
    end
    check("acc_sat_out", got, -16777215);

    // 5. Busy rules.
    reset_dut();
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'($urandom_range(0, 4095) - 2048));
    write_coef(3'd6, W'(12345));
    write_coef(3'd5, W'(777));
    send_sample(W'($urandom_range(0, 65535) - 32768), 2, 0, got, b0);
    send_sample(W'($urandom_range(0, 65535) - 32768), 0, 3, got, b0);
    send_sample(W'($urandom_range(0, 65535) - 32768), 0, 0, got, b0);

    // 6. Reset mid-MAC.
    reset_dut();
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'(imp_tab[k]));
    send_sample(W'(999), 0, 0, got, b0);
    wait_idle();
    muestra_in = W'(1024); muestra_valid = 1'b1;
    @(posedge clk);
    #1 muestra_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ocupado", ocupado, 0);
    check("midrst_suma_a", suma_a, 0);
    check("midrst_suma_b", suma_b, 0);
    check("midrst_salida", salida, 0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 if (salida_valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", vcount, 0);
    send_sample(W'(1024), 0, 0, got, b0);
    check("midrst_h_cleared", got, 0);
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'(imp_tab[k]));
    for (int i = 1; i < NT; i++) send_sample(W'(0), 0, 0, got, b0);
    for (int i = 0; i < NT; i++) begin
      send_sample((i == 0) ? W'(1024) : W'(0), 0, 0, got, b0);
      check("midrst_impulse", got, imp_tab[i]);
    end

    // 7. Random traffic against the reference model.
    reset_dut();
    for (int k = 0; k < NT; k++) write_coef(3'(k), W'($urandom_range(0, 16383) - 8192));
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tmp = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 16383)) - 8192
                                          : sx(W'($urandom));
        write_coef(3'($urandom_range(0, 7)), W'(tmp));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      tmp = ($urandom_range(0, 2) == 0) ? sx(W'($urandom))
                                        : longint'($urandom_range(0, 262143)) - 131072;
      send_sample(W'(tmp), ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : 0,
                  0, got, b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_secuencial.md
Name: fir_mac_secuencial

Overview:
- Time-multiplexed tap engine of the non-recursive filter; sits directly upstream of the saturating adder Suma and feeds it.
- Per accepted sample: shifts the delay line, then walks all taps, one per clock.
- Each tap cycle: drives `suma_a` = accumulator and `suma_b` = saturated, rescaled product x[k]*h[k]; registers Suma's `suma_y` back into the accumulator.
- Presents the filtered sample with a one-cycle valid strobe.

Parameters:
- Width, 25: signed sample/coefficient/accumulator width (matches Suma Width).
- Frac, 10: fractional bits of coefficients; product is arithmetically shifted right by Frac.
- Taps, 5: number of filter taps (≥2).
- AddrW, 3: coefficient address width, 2**AddrW ≥ Taps.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- muestra_in  in  Width  signed input sample.
- muestra_valid  in  1  sample strobe, sampled on clk.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  AddrW  coefficient index.
- coef_in  in  Width  signed coefficient, Q(Width-Frac).Frac.
- suma_a  out  Width  to Suma A: accumulator.
- suma_b  out  Width  to Suma B: saturated scaled product.
- suma_y  in  Width  from Suma Y (combinational, same cycle).
- salida  out  Width  filtered sample, registered.
- salida_valid  out  1  one-cycle strobe, registered.
- ocupado  out  1  high whenever state ≠ IDLE.

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset (`rst_n` = 0, asynchronous):
  - state = IDLE; delay line x[0..Taps-1] = 0; coefs h[0..Taps-1] = 0; acc = 0; idx = 0.
  - `salida` = 0, `salida_valid` = 0, `ocupado` = 0, `suma_a` = 0, `suma_b` = 0.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - On `muestra_valid` = 1 at edge E0: x[0] <= `muestra_in`; x[k] <= x[k-1]; acc <= 0; idx <= 0; -> MAC.
  - Otherwise stay in IDLE.
- MAC:
  - `suma_a` = acc, `suma_b` = sat(x[idx]*h[idx]).
  - Each edge: acc <= `suma_y`; idx <= idx+1.
  - Edge with idx = Taps-1: -> DONE.
  - MAC occupies edges E1..E_Taps.
- DONE: at edge E_{Taps+1}: `salida` <= acc; `salida_valid` <= 1; -> IDLE.
- `salida_valid` is high for exactly one cycle, after E_{Taps+1}; cleared on the next edge.
- `salida` holds its value until the next result.
- Earliest next sample accepted at E_{Taps+2}; throughput is one sample per Taps+2 clocks.
- `suma_a` and `suma_b` are 0 outside MAC.
- Product rule:
  - p = signed Width×Width -> 2·Width-bit full product; s = p >>> Frac (arithmetic shift).
  - If s > 2^(Width-1)-1, sat = 2^(Width-1)-1.
  - If s < -(2^(Width-1)-1), sat = -(2^(Width-1)-1). The range is symmetric, same as Suma.
  - Otherwise sat = s[Width-1:0].
- Accumulation saturation is Suma's job; this block only registers `suma_y`.
- `muestra_valid` while `ocupado` = 1: sample dropped, delay line untouched.
- Coefficient writes:
  - Accepted only when state = IDLE and `coef_addr` < Taps: h[coef_addr] <= `coef_in`.
  - Otherwise ignored.
- Write and `muestra_valid` at the same IDLE edge: both take effect. The new h is used in the MAC that follows.
- `rst_n` asserted mid-MAC or in DONE: immediate return to reset values; the partial result is discarded and no `salida_valid` is emitted.

Test Plan:
1. Reset with `muestra_valid` = 1, `coef_we` = 1 -> `salida` = 0, `salida_valid` = 0, `ocupado` = 0, `suma_a` = `suma_b` = 0; a later impulse with no coef writes -> output 0.
2. Impulse response:
   - Stimulus: Taps = 5, Frac = 10; h = {1024, 2048, 3072, 4096, 5120}; x = 1024 then four zeros, each sent when `ocupado` = 0.
   - Required response: `salida` = 1024, 2048, 3072, 4096, 5120; each `salida_valid` pulse exactly 6 clocks after its accepted sample.
3. Product saturation: h[0] = 16777215, x = 16777215 -> during MAC idx 0, `suma_b` = 16777215; final `salida` = 16777215.
4. Accumulator saturation through Suma:
   - Stimulus: all h = 8192 (8.0); five samples of x = -2097152.
   - Required response: each product = -16777215 (clamped); fifth `salida` = -16777215, with no wrap to positive.
5. Busy rules:
   - `muestra_valid` pulse 2 clocks after acceptance -> ignored; the next result equals the no-pulse result.
   - `coef_we` to addr 0 during MAC -> h[0] unchanged.
   - `coef_addr` = 6 -> ignored.
6. Reset mid-MAC:
   - Stimulus: deassert `rst_n` at idx = 2 for one cycle.
   - Required response: no `salida_valid`, `ocupado` = 0 immediately, x and h cleared; a new impulse after re-writing h reproduces scenario 2 values.
